// File: rtl/nibble_serial_adder_if.sv
// Handshake bundle for nibble_serial_adder: operand side and result side.
// ovf exists only when NIBBLE_SERIAL_OVF_EN is defined.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
`ifdef NIBBLE_SERIAL_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
`else
    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out
    );
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit ripple slice reused per nibble.
// Optional signed overflow flag under NIBBLE_SERIAL_OVF_EN.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input logic                 clk,
    input logic                 reset,
    nibble_serial_adder_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [KW-1:0]    k_q;
    logic             carry_q;
    logic             c_out_q;
    logic             in_ready;
    logic             out_valid;
    logic             last;

    logic [KW+1:0]    sh;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       slice_s;
    logic             slice_c;
    logic [WIDTH-1:0] nib_mask;
    logic [WIDTH-1:0] sum_next;

`ifdef NIBBLE_SERIAL_OVF_EN
    logic             c_msb;
    logic             ovf_q;
`endif

    assign last = (k_q == KW'(NIB - 1));

    // Select the active nibble by shifting, so no variable part-select is needed.
    assign sh    = {k_q, 2'b00};
    assign a_sh  = a_q >> sh;
    assign b_sh  = b_q >> sh;
    assign nib_a = a_sh[3:0];
    assign nib_b = b_sh[3:0];

    always_comb begin
        logic cy;
        cy = carry_q;
`ifdef NIBBLE_SERIAL_OVF_EN
        c_msb = 1'b0;
`endif
        for (int i = 0; i < 4; i++) begin
`ifdef NIBBLE_SERIAL_OVF_EN
            if (i == 3) c_msb = cy;
`endif
            slice_s[i] = nib_a[i] ^ nib_b[i] ^ cy;
            cy = (nib_a[i] & nib_b[i]) | (cy & (nib_a[i] ^ nib_b[i]));
        end
        slice_c = cy;
    end

    assign nib_mask = WIDTH'(4'hF) << sh;
    assign sum_next = (sum_q & ~nib_mask) | (WIDTH'(slice_s) << sh);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_d = ADD;
            end
            ADD: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
`ifdef NIBBLE_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= bus.c_in;
                        k_q     <= '0;
                    end
                end
                ADD: begin
                    sum_q   <= sum_next;
                    carry_q <= slice_c;
                    k_q     <= k_q + 1'b1;
                    if (last) begin
                        c_out_q <= slice_c;
`ifdef NIBBLE_SERIAL_OVF_EN
                        ovf_q   <= c_msb ^ slice_c;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
`ifdef NIBBLE_SERIAL_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16 plus a WIDTH=4 instance).
// ovf checks compile in when NIBBLE_SERIAL_OVF_EN is defined.
module tb_nibble_serial_adder;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_adder_if #(.WIDTH(16)) bus ();
    nibble_serial_adder_if #(.WIDTH(4))  bus4 ();

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    // Accept one operation, then count edges until out_valid (0 = accept edge).
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, output int edges);
        bus.a = av;
        bus.b = bv;
        bus.c_in = ci;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        edges = 0;
        while (!bus.out_valid && edges < 20) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.sum, bus.c_out} !== {2'b10, 16'h0, 1'b0})
            $display("FAIL reset_state rdy=%b vld=%b sum=%h c=%b want 1 0 0000 0",
                     bus.in_ready, bus.out_valid, bus.sum, bus.c_out);
        else passed++;
`ifdef NIBBLE_SERIAL_OVF_EN
        checks++;
        if (bus.ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", bus.ovf);
        else passed++;
`endif
        checks++;
        if ({bus4.in_ready, bus4.out_valid} !== 2'b10)
            $display("FAIL reset_w4 rdy=%b vld=%b want 1 0", bus4.in_ready, bus4.out_valid);
        else passed++;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10)
            $display("FAIL post_reset_idle rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid);
        else passed++;
    endtask

    task automatic test_basic();
        int e;
        bus.out_ready = 1'b1;
        run_op(16'h00FF, 16'h0001, 1'b0, e);
        checks++;
        if (e !== 4) $display("FAIL basic_latency got %0d want 4", e);
        else passed++;
        checks++;
        if ({bus.sum, bus.c_out} !== {16'h0100, 1'b0})
            $display("FAIL basic_sum got %h c=%b want 0100 c=0", bus.sum, bus.c_out);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10)
            $display("FAIL basic_return rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid);
        else passed++;
    endtask

    task automatic test_ripple();
        int e;
        bus.out_ready = 1'b1;
        run_op(16'hFFFF, 16'h0001, 1'b0, e);
        checks++;
        if ({bus.sum, bus.c_out} !== {16'h0000, 1'b1} || e !== 4)
            $display("FAIL ripple_sum got %h c=%b lat=%0d want 0000 c=1 lat=4",
                     bus.sum, bus.c_out, e);
        else passed++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_hold();
        int e;
        bit seen;
        bus.out_ready = 1'b0;
        run_op(16'h1234, 16'h4321, 1'b1, e);
        checks++;
        if ({bus.sum, bus.c_out} !== {16'h5556, 1'b0} || e !== 4)
            $display("FAIL hold_sum got %h c=%b lat=%0d want 5556 c=0 lat=4",
                     bus.sum, bus.c_out, e);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.a = 16'hAAAA;
            bus.b = 16'h5555;
            bus.c_in = 1'b1;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.sum, bus.c_out} !== {2'b10, 16'h5556, 1'b0})
                $display("FAIL hold_cycle%0d vld=%b rdy=%b sum=%h c=%b want 1 0 5556 0",
                         i, bus.out_valid, bus.in_ready, bus.sum, bus.c_out);
            else passed++;
        end
`ifdef NIBBLE_SERIAL_OVF_EN
        checks++;
        if (bus.ovf !== 1'b0) $display("FAIL hold_ovf got %b want 0", bus.ovf);
        else passed++;
`endif
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10)
            $display("FAIL hold_release rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid);
        else passed++;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) $display("FAIL hold_ignored_input got out_valid=1 want 0");
        else passed++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        bus.out_ready = 1'b1;
        bus.a = 16'h0F0F;
        bus.b = 16'h0101;
        bus.c_in = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.sum, bus.c_out} !== {2'b01, 16'h0, 1'b0})
            $display("FAIL reset_mid vld=%b rdy=%b sum=%h c=%b want 0 1 0000 0",
                     bus.out_valid, bus.in_ready, bus.sum, bus.c_out);
        else passed++;
        reset = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) $display("FAIL reset_mid_dropped got out_valid=1 want 0");
        else passed++;
    endtask

`ifdef NIBBLE_SERIAL_OVF_EN
    task automatic test_ovf();
        int e;
        bus.out_ready = 1'b1;
        run_op(16'h7FFF, 16'h0001, 1'b0, e);
        checks++;
        if ({bus.sum, bus.c_out, bus.ovf} !== {16'h8000, 1'b0, 1'b1})
            $display("FAIL ovf_pos got %h c=%b v=%b want 8000 c=0 v=1",
                     bus.sum, bus.c_out, bus.ovf);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        run_op(16'hFFFF, 16'h0001, 1'b0, e);
        checks++;
        if ({bus.sum, bus.c_out, bus.ovf} !== {16'h0000, 1'b1, 1'b0})
            $display("FAIL ovf_neg got %h c=%b v=%b want 0000 c=1 v=0",
                     bus.sum, bus.c_out, bus.ovf);
        else passed++;
        @(posedge clk);
        @(negedge clk);
    endtask
`endif

    task automatic test_back_to_back();
        int t[3];
        int n;
        int budget;
        bus.a = 16'h0001;
        bus.b = 16'h0001;
        bus.c_in = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        n = 0;
        budget = 0;
        while (n < 3 && budget < 40) begin
            @(posedge clk);
            @(negedge clk);
            budget++;
            if (bus.out_valid) begin
                t[n] = cyc;
                checks++;
                if (bus.sum !== 16'h0002)
                    $display("FAIL b2b_sum%0d got %h want 0002", n, bus.sum);
                else passed++;
                n++;
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (n !== 3) $display("FAIL b2b_count got %0d want 3", n);
        else passed++;
        if (n == 3) begin
            checks++;
            if (t[1] - t[0] !== 6) $display("FAIL b2b_gap0 got %0d want 6", t[1] - t[0]);
            else passed++;
            checks++;
            if (t[2] - t[1] !== 6) $display("FAIL b2b_gap1 got %0d want 6", t[2] - t[1]);
            else passed++;
        end
        repeat (8) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_width4();
        int e;
        bus4.out_ready = 1'b1;
        bus4.a = 4'hF;
        bus4.b = 4'h1;
        bus4.c_in = 1'b0;
        bus4.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        e = 0;
        while (!bus4.out_valid && e < 10) begin
            @(posedge clk);
            @(negedge clk);
            e++;
        end
        checks++;
        if ({bus4.sum, bus4.c_out} !== {4'h0, 1'b1} || e !== 1)
            $display("FAIL w4_sum got %h c=%b lat=%0d want 0 c=1 lat=1",
                     bus4.sum, bus4.c_out, e);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus4.in_ready, bus4.out_valid} !== 2'b10)
            $display("FAIL w4_return rdy=%b vld=%b want 1 0", bus4.in_ready, bus4.out_valid);
        else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.c_in = 1'b0;
        bus.out_ready = 1'b0;
        bus4.in_valid = 1'b0;
        bus4.a = '0;
        bus4.b = '0;
        bus4.c_in = 1'b0;
        bus4.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_ripple();
        test_hold();
        test_reset_mid();
`ifdef NIBBLE_SERIAL_OVF_EN
        test_ovf();
`endif
        test_back_to_back();
        test_width4();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
